// File: rtl/ifetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package ifetch_unit_pkg;

  // One buffered fetch result: the PC it was fetched from and the instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instn;
  } fetch_entry_t;

  // Canonical bubble instruction (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTN = 32'h0000_0013;

  // RUN: every response is kept. DRAIN: stale responses from before a redirect are being dropped.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Sequential next PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/ifetch_unit_chk.sv
// Protocol and invariant checks for the fetch unit (simulation only).
module ifetch_unit_chk #(
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   resp_valid,
  input logic [$clog2(DEPTH):0] inflight,
  input logic [$clog2(DEPTH):0] count
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CWP = CW + 1;

  // A response with nothing outstanding is a memory protocol error.
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (!reset)
    resp_valid |-> (inflight != {CW{1'b0}}));

  // Credit accounting must never allow more than DEPTH entries held plus outstanding.
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
    (({1'b0, count} + {1'b0, inflight}) <= CWP'(DEPTH)));

endmodule

// File: rtl/ifetch_unit_fetch_fifo.sv
// Small synchronous FIFO of fetch entries; clear has priority over push/pop.
module fetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  // Never write a full queue or read an empty one, even if the caller misbehaves.
  assign do_push_s = push & (count_r < CW'(DEPTH));
  assign do_pop_s  = pop & (count_r != {CW{1'b0}});

  // Entry storage; written only on an accepted push outside a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
      end
    end else if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign valid = (count_r != {CW{1'b0}});

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited request issue,
// in-order response buffering and redirect handling with stale-response drop.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  ifetch_unit_if.master       imem,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                stallD,
  output logic                validF,
  output logic [31:0]         instnF,
  output logic [31:0]         pcF,
  output logic [31:0]         pcplus4F
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CWP = CW + 1;

  logic [31:0]  fetch_pc_r;
  logic [31:0]  resp_pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_cnt_r;
  fetch_state_t state_r;

  logic [31:0]  fetch_pc_nxt_s;
  logic [31:0]  resp_pc_nxt_s;
  logic [CW-1:0] inflight_nxt_s;
  logic [CW-1:0] drop_cnt_nxt_s;
  fetch_state_t state_nxt_s;

  logic          resp_ok_s;
  logic          credit_ok_s;
  logic          req_valid_s;
  logic          fire_s;
  logic          push_s;
  logic          pop_s;
  logic          clear_s;
  logic [CW-1:0] count_s;
  logic          fifo_valid_s;
  fetch_entry_t  head_s;
  fetch_entry_t  din_s;

  // Responses with nothing outstanding are ignored entirely.
  assign resp_ok_s   = imem.imem_resp_valid & (inflight_r != {CW{1'b0}});
  assign credit_ok_s = ({1'b0, count_s} + {1'b0, inflight_r}) < CWP'(DEPTH);
  assign req_valid_s = reset & ~redirect & credit_ok_s;
  assign fire_s      = req_valid_s & imem.imem_req_ready;

  assign imem.imem_req_valid = req_valid_s;
  assign imem.imem_req_addr  = fetch_pc_r;

  assign din_s = '{pc: resp_pc_r, instn: imem.imem_resp_data};

  // Next-state logic: redirect overrides everything; otherwise keep or drop responses by state.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    resp_pc_nxt_s  = resp_pc_r;
    inflight_nxt_s = inflight_r + CW'(fire_s) - CW'(resp_ok_s);
    drop_cnt_nxt_s = drop_cnt_r;
    state_nxt_s    = state_r;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    clear_s        = 1'b0;
    if (redirect) begin
      clear_s        = 1'b1;
      fetch_pc_nxt_s = redirect_pc;
      resp_pc_nxt_s  = redirect_pc;
      // Everything still outstanding after this cycle's response belongs to the old path.
      drop_cnt_nxt_s = inflight_r - CW'(resp_ok_s);
      if (drop_cnt_nxt_s != {CW{1'b0}}) begin
        state_nxt_s = DRAIN;
      end else begin
        state_nxt_s = RUN;
      end
    end else begin
      pop_s = fifo_valid_s & ~stallD;
      if (fire_s) begin
        fetch_pc_nxt_s = pc_plus4(fetch_pc_r);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      case (state_r)
        RUN: begin
          if (resp_ok_s) begin
            push_s        = 1'b1;
            resp_pc_nxt_s = pc_plus4(resp_pc_r);
          end else begin
            push_s        = 1'b0;
            resp_pc_nxt_s = resp_pc_r;
          end
          state_nxt_s = RUN;
        end
        DRAIN: begin
          if (resp_ok_s && (drop_cnt_r != {CW{1'b0}})) begin
            drop_cnt_nxt_s = drop_cnt_r - CW'(1);
          end else begin
            drop_cnt_nxt_s = drop_cnt_r;
          end
          if (drop_cnt_nxt_s == {CW{1'b0}}) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        default: begin
          state_nxt_s    = RUN;
          drop_cnt_nxt_s = {CW{1'b0}};
        end
      endcase
    end
  end

  // PC, credit and drop-count registers plus FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
      state_r    <= RUN;
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      resp_pc_r  <= resp_pc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
      state_r    <= state_nxt_s;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .clear (clear_s),
    .din   (din_s),
    .head  (head_s),
    .count (count_s),
    .valid (fifo_valid_s)
  );

  ifetch_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .resp_valid (imem.imem_resp_valid),
    .inflight   (inflight_r),
    .count      (count_s)
  );

  // Outputs come straight from the queue head registers and are zeroed when empty.
  assign validF   = fifo_valid_s;
  assign instnF   = fifo_valid_s ? head_s.instn : 32'h0000_0000;
  assign pcF      = fifo_valid_s ? head_s.pc : 32'h0000_0000;
  assign pcplus4F = fifo_valid_s ? pc_plus4(head_s.pc) : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against an epoch-tagged queue model.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stallD;
  logic        validF;
  logic [31:0] instnF;
  logic [31:0] pcF;
  logic [31:0] pcplus4F;

  ifetch_unit_if bus();

  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stallD      (stallD),
    .validF      (validF),
    .instnF      (instnF),
    .pcF         (pcF),
    .pcplus4F    (pcplus4F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory requests tagged with the fetch epoch in force when they were issued.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instn;
  } ent_t;

  mreq_t       mq[$];
  ent_t        hq[$];
  int          epoch;
  logic [31:0] nxt_pc;
  int          cyc;
  logic        exp_rv_q;

  int p_stall, p_ready, p_resp, p_redir, lat_lo, lat_hi;
  bit          force_redir;
  bit          force_on_resp;
  logic [31:0] force_pc;
  logic        last_validF;
  logic [31:0] last_pcF;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[5:2] == 4'h0) return NOP_INSTN;
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    hq.delete();
    mq.delete();
    epoch++;
    nxt_pc = RESET_PC;
  endtask

  task automatic drive_inputs();
    logic [31:0] rp;
    if (!reset) begin
      stallD = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;
      return;
    end
    stallD = ($urandom_range(0, 99) < p_stall);
    bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    if (mq.size() > 0 && mq[0].due <= cyc && ($urandom_range(0, 99) < p_resp)) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom();
    end
    rp = $urandom();
    rp[1:0] = 2'b00;
    if ($urandom_range(0, 3) == 0) rp = {28'hFFF_FFFF, rp[3:2], 2'b00};
    redirect    = ($urandom_range(0, 99) < p_redir);
    redirect_pc = rp;
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
    end
    if (force_on_resp && bus.imem_resp_valid && hq.size() > 0 && !stallD) begin
      redirect = 1'b1; redirect_pc = force_pc; force_on_resp = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic ev;
    exp_rv_q    = reset && !redirect && ((hq.size() + mq.size()) < DEPTH);
    last_validF = validF;
    last_pcF    = pcF;
    check_eq("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_rv_q});
    if (exp_rv_q) check_eq("req_addr", bus.imem_req_addr, nxt_pc);
    ev = (hq.size() > 0);
    check_eq("validF", {31'd0, validF}, {31'd0, ev});
    if (ev) begin
      check_eq("pcF", pcF, hq[0].pc);
      check_eq("instnF", instnF, hq[0].instn);
      check_eq("pcplus4F", pcplus4F, hq[0].pc + 32'd4);
    end else begin
      check_eq("pcF_idle", pcF, 32'h0);
      check_eq("instnF_idle", instnF, 32'h0);
      check_eq("pcplus4F_idle", pcplus4F, 32'h0);
    end
    check_eq("inflight", 32'(dut.inflight_r), 32'(mq.size()));
    check_eq("drop_cnt", 32'(dut.drop_cnt_r), 32'(stale_count()));
    check_eq("state", 32'(dut.state_r), (stale_count() > 0) ? 32'(DRAIN) : 32'(RUN));
  endtask

  task automatic update_model();
    mreq_t r;
    bit    keep;
    cyc++;
    if (!reset) return;
    keep = 1'b0;
    if (bus.imem_resp_valid) begin
      r = mq.pop_front();
      keep = (r.epoch == epoch);
    end
    if (redirect) begin
      hq.delete();
      epoch++;
      nxt_pc = redirect_pc;
    end else begin
      if (hq.size() > 0 && !stallD) hq.delete(0);
      if (keep) hq.push_back('{pc: r.addr, instn: mem_word(r.addr)});
      if (exp_rv_q && bus.imem_req_ready) begin
        mq.push_back('{addr: nxt_pc, epoch: epoch, due: (cyc - 1) + int'($urandom_range(lat_lo, lat_hi))});
        nxt_pc = nxt_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic knobs(input int s, input int rd, input int rs, input int rr, input int lo, input int hi);
    p_stall = s; p_ready = rd; p_resp = rs; p_redir = rr; lat_lo = lo; lat_hi = hi;
  endtask

  initial begin
    int first;
    epoch = 0; cyc = 0; force_redir = 1'b0; force_on_resp = 1'b0; force_pc = 32'h0;
    reset = 1'b0;
    knobs(0, 100, 100, 0, 1, 1);
    model_reset();
    repeat (2) tick();

    // Test 1: streaming after reset release, latency 1
    reset = 1'b1;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (first == 0 && last_validF) first = i;
    end
    check_eq("first_validF_cycle", 32'(first), 32'd3);

    // Test 2: decode stall for 5 cycles, then release
    knobs(100, 100, 100, 0, 1, 1);
    repeat (5) tick();
    knobs(0, 100, 100, 0, 1, 1);
    repeat (20) tick();

    // Test 3: redirect to 0x100 with two requests outstanding, latency 3
    knobs(0, 100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && mq.size() != 2; i++) tick();
    check_eq("two_inflight_reached", 32'(mq.size()), 32'd2);
    force_pc = 32'h0000_0100; force_redir = 1'b1;
    tick();
    last_validF = 1'b0;
    for (int i = 0; i < 30 && !last_validF; i++) tick();
    check_eq("redir_first_pc", last_pcF, 32'h0000_0100);
    repeat (10) tick();

    // Test 4: redirect coinciding with a response and a pop
    knobs(0, 100, 100, 0, 1, 1);
    force_pc = 32'h0000_2000; force_on_resp = 1'b1;
    for (int i = 0; i < 40 && force_on_resp; i++) tick();
    check_eq("redir_resp_pop_hit", {31'd0, force_on_resp}, 32'd0);
    force_on_resp = 1'b0;
    repeat (10) tick();

    // Test 5: memory not ready for 4 cycles
    knobs(0, 0, 100, 0, 1, 1);
    repeat (4) tick();
    knobs(0, 100, 100, 0, 1, 2);
    repeat (10) tick();

    // Test 6: reset mid-stream with the queue full
    knobs(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 20 && hq.size() != DEPTH; i++) tick();
    check_eq("queue_full_reached", 32'(hq.size()), 32'(DEPTH));
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_validF", {31'd0, validF}, 32'd0);
    check_eq("rst_pcF", pcF, 32'h0);
    check_eq("rst_instnF", instnF, 32'h0);
    check_eq("rst_pcplus4F", pcplus4F, 32'h0);
    check_eq("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    knobs(0, 100, 100, 0, 1, 1);
    repeat (15) tick();

    // PC wrap across 2^32
    force_pc = 32'hFFFF_FFF8; force_redir = 1'b1;
    repeat (20) tick();

    // Randomized mix of stalls, backpressure, latency and redirects
    for (int blk = 0; blk < 8; blk++) begin
      knobs($urandom_range(0, 60), $urandom_range(30, 100), $urandom_range(40, 100),
            $urandom_range(0, 8), 1, $urandom_range(1, 4));
      repeat (100) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
